// File: rtl/nfc_pkg.sv
// Command codes, status bytes and FSM state encoding for the NAND flash responder.
package nfc_pkg;
  localparam logic [7:0] CMD_READ0    = 8'h00;
  localparam logic [7:0] CMD_READ1    = 8'h01;
  localparam logic [7:0] CMD_PROG     = 8'h80;
  localparam logic [7:0] CMD_PROG_CFM = 8'h10;
  localparam logic [7:0] CMD_STATUS   = 8'h70;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam logic [7:0] STATUS_READY = 8'hC0;
  localparam logic [7:0] STATUS_BUSY  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_LOAD, ST_RD_DATA, ST_PROG_DATA, ST_STORE, ST_STATUS
  } nfr_state_e;
endpackage

// File: rtl/nfr_page_buf.sv
// One-page byte buffer: single write port, registered read port.
module nfr_page_buf #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end
endmodule

// File: rtl/nand_flash_responder.sv
// NAND flash device model: decodes host cycles, buffers one page and moves
// pages to/from an external byte memory while F_RB is low.
module nand_flash_responder
  import nfc_pkg::*;
#(
  parameter  int PAGE_SIZE = 512,
  parameter  int ROW_W     = 9,
  localparam int COL_W     = $clog2(PAGE_SIZE)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   F_CLE,
  input  logic                   F_ALE,
  input  logic                   F_WEN,
  input  logic                   F_REN,
  input  logic [7:0]             F_IO_IN,
  output logic [7:0]             F_IO_OUT,
  output logic                   F_IO_OE,
  output logic                   F_RB,
  output logic [COL_W+ROW_W-1:0] mem_addr,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata
);
  localparam logic [COL_W:0] CNT_PG = (COL_W+1)'(PAGE_SIZE);

  nfr_state_e state, state_d, ret_state, ret_d, eng, nxt;
  logic [COL_W-1:0] col, col_d, ld_col, buf_wa, buf_ra;
  logic [ROW_W-1:0] row, row_d;
  logic [COL_W:0]   cnt, cnt_d;
  logic [1:0]       acnt, acnt_d;
  logic [COL_W+ROW_W-1:0] mem_addr_d;
  logic [7:0] out_d, buf_wd, buf_rd;
  logic prog, prog_d, rb_d, oe_d, mem_re_d, mem_we_d, ld_vld, done, busy, buf_we;
  logic wen_q, ren_q, wen_rise, ren_fall, ren_rise, is_cmd, is_addr, is_data;

  assign wen_rise  = F_WEN & ~wen_q;
  assign ren_fall  = ~F_REN & ren_q;
  assign ren_rise  = F_REN & ~ren_q;
  assign is_cmd    = wen_rise & F_CLE & ~F_ALE;
  assign is_addr   = wen_rise & F_ALE & ~F_CLE;
  assign is_data   = wen_rise & ~F_CLE & ~F_ALE;
  assign mem_wdata = buf_rd;

  nfr_page_buf #(.DEPTH(PAGE_SIZE), .AW(COL_W)) u_buf (
    .clk(clk), .rst(rst), .we(buf_we), .waddr(buf_wa), .wdata(buf_wd),
    .raddr(buf_ra), .rdata(buf_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE; ret_state <= ST_IDLE;
      col <= '0; row <= '0; cnt <= '0; acnt <= '0; prog <= 1'b0;
      F_RB <= 1'b1; F_IO_OE <= 1'b0; F_IO_OUT <= '0;
      mem_re <= 1'b0; mem_we <= 1'b0; mem_addr <= '0;
      ld_vld <= 1'b0; ld_col <= '0;
      wen_q <= 1'b1; ren_q <= 1'b1;
    end else begin
      state <= state_d; ret_state <= ret_d;
      col <= col_d; row <= row_d; cnt <= cnt_d; acnt <= acnt_d; prog <= prog_d;
      F_RB <= rb_d; F_IO_OE <= oe_d; F_IO_OUT <= out_d;
      mem_re <= mem_re_d; mem_we <= mem_we_d; mem_addr <= mem_addr_d;
      ld_vld <= mem_re; ld_col <= mem_addr[COL_W-1:0];
      wen_q <= F_WEN; ren_q <= F_REN;
    end
  end

  always_comb begin
    state_d = state; ret_d = ret_state;
    col_d = col; row_d = row; cnt_d = cnt; acnt_d = acnt; prog_d = prog;
    rb_d = F_RB; oe_d = F_IO_OE; out_d = F_IO_OUT;
    mem_re_d = 1'b0; mem_we_d = 1'b0; mem_addr_d = mem_addr;
    buf_we = 1'b0; buf_wa = col; buf_wd = F_IO_IN;
    done = 1'b0; nxt = ST_IDLE;
    // A status read parks the FSM in STATUS but the page transfer keeps running.
    eng  = (state == ST_STATUS) ? ret_state : state;
    busy = (eng == ST_LOAD) || (eng == ST_STORE);
    buf_ra = (eng == ST_STORE) ? cnt[COL_W-1:0] : col;

    if (eng == ST_LOAD) begin
      cnt_d = cnt + 1'b1;
      if (cnt < CNT_PG) begin
        mem_re_d   = 1'b1;
        mem_addr_d = {row, cnt[COL_W-1:0]};
      end
      if (ld_vld) begin
        buf_we = 1'b1; buf_wa = ld_col; buf_wd = mem_rdata;
      end
      if (cnt == CNT_PG + 1'b1) begin done = 1'b1; nxt = ST_RD_DATA; end
    end else if (eng == ST_STORE) begin
      cnt_d = cnt + 1'b1;
      if (cnt < CNT_PG) begin
        mem_we_d   = 1'b1;
        mem_addr_d = {row, cnt[COL_W-1:0]};
      end
      if (cnt == CNT_PG) begin done = 1'b1; nxt = ST_IDLE; end
    end
    if (done) begin
      rb_d = 1'b1;
      if (state == ST_STATUS) ret_d = nxt;
      else                    state_d = nxt;
    end

    if (ren_fall && state == ST_RD_DATA) begin oe_d = 1'b1; out_d = buf_rd; end
    if (ren_fall && state == ST_STATUS) begin
      oe_d = 1'b1; out_d = F_RB ? STATUS_READY : STATUS_BUSY;
    end
    if (ren_rise) begin
      oe_d = 1'b0;
      if (state == ST_RD_DATA) col_d = col + 1'b1;
    end

    if (is_cmd) begin
      if (F_IO_IN == CMD_RESET) begin
        state_d = ST_IDLE; ret_d = ST_IDLE; col_d = '0; acnt_d = '0;
        rb_d = 1'b1; oe_d = 1'b0; mem_re_d = 1'b0; mem_we_d = 1'b0; buf_we = 1'b0;
      end else if (F_IO_IN == CMD_STATUS) begin
        if (state != ST_STATUS) begin ret_d = state_d; state_d = ST_STATUS; end
      end else if (!busy) begin
        case (F_IO_IN)
          CMD_READ0, CMD_READ1: begin
            if (state == ST_STATUS && F_IO_IN == CMD_READ0) state_d = ST_RD_DATA;
            else begin
              state_d = ST_ADDR; prog_d = 1'b0; acnt_d = '0;
              col_d[COL_W-1] = F_IO_IN[0];
            end
          end
          CMD_PROG: begin state_d = ST_ADDR; prog_d = 1'b1; acnt_d = '0; end
          CMD_PROG_CFM: if (state == ST_PROG_DATA) begin
            state_d = ST_STORE; rb_d = 1'b0; cnt_d = '0;
          end
          default: ;
        endcase
      end
    end

    if (is_addr && state == ST_ADDR) begin
      acnt_d = acnt + 1'b1;
      case (acnt)
        2'd0:    col_d[7:0] = F_IO_IN;
        2'd1:    row_d[7:0] = F_IO_IN;
        default: begin
          row_d[ROW_W-1:8] = F_IO_IN[ROW_W-9:0];
          if (prog) state_d = ST_PROG_DATA;
          else begin state_d = ST_LOAD; rb_d = 1'b0; cnt_d = '0; end
        end
      endcase
    end

    if (is_data && state == ST_PROG_DATA) begin
      buf_we = 1'b1; buf_wa = col; buf_wd = F_IO_IN; col_d = col + 1'b1;
    end
  end
endmodule

// File: tb/tb_nand_flash_responder.sv
// Randomized bench: host-side bus tasks plus a page/buffer/column reference model.
module tb_nand_flash_responder;
  import nfc_pkg::*;
  localparam int PS = 512, RW = 9, MEM_SZ = PS << RW;

  logic clk = 1'b0, rst = 1'b0;
  logic F_CLE = 1'b0, F_ALE = 1'b0, F_WEN = 1'b1, F_REN = 1'b1;
  logic [7:0] F_IO_IN = '0, F_IO_OUT, mem_wdata, mem_rdata = '0;
  logic F_IO_OE, F_RB, mem_re, mem_we, init_mem = 1'b0;
  logic [17:0] mem_addr;

  logic [7:0] mem [MEM_SZ];
  logic [7:0] ref_mem [MEM_SZ];
  logic [7:0] ref_buf [PS];
  int ref_col = 0;
  int n_chk = 0, n_err = 0;
  int rb_run = 0, rb_low_len = 0;

  nand_flash_responder #(.PAGE_SIZE(PS), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN), .F_REN(F_REN),
    .F_IO_IN(F_IO_IN), .F_IO_OUT(F_IO_OUT), .F_IO_OE(F_IO_OE), .F_RB(F_RB),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // External byte memory: read data one cycle after mem_re.
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < MEM_SZ; i++) mem[i] <= ref_mem[i];
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Length of the most recent busy pulse, in cycles.
  always @(negedge clk) begin
    if (!F_RB) rb_run <= rb_run + 1;
    else if (rb_run != 0) begin rb_low_len <= rb_run; rb_run <= 0; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic cle, input logic ale, input logic [7:0] d);
    @(negedge clk); F_CLE = cle; F_ALE = ale; F_IO_IN = d; F_WEN = 1'b0;
    repeat (2) @(negedge clk);
    F_WEN = 1'b1;
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] c); host_wr(1'b1, 1'b0, c); endtask

  task automatic addr3(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    host_wr(1'b0, 1'b1, a0); host_wr(1'b0, 1'b1, a1); host_wr(1'b0, 1'b1, a2);
  endtask

  task automatic host_rd(output logic [7:0] v);
    @(negedge clk); F_REN = 1'b0;
    @(negedge clk); chk("oe_on", F_IO_OE, 1); v = F_IO_OUT;
    @(negedge clk); F_REN = 1'b1;
    @(negedge clk); chk("oe_off", F_IO_OE, 0);
  endtask

  task automatic wait_rb(input int exp_low, input string tag);
    int n = 0;
    while (F_RB !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    @(negedge clk);
    chk({tag, "_ready"}, F_RB, 1);
    chk({tag, "_busy_len"}, rb_low_len, exp_low);
  endtask

  function automatic logic [7:0] m_next();
    logic [7:0] b = ref_buf[ref_col];
    ref_col = (ref_col + 1) % PS;
    return b;
  endfunction

  task automatic do_read_setup(input int row, input int col);
    cmd(col[8] ? CMD_READ1 : CMD_READ0);
    addr3(col[7:0], row[7:0], {7'b0, row[8]});
    for (int i = 0; i < PS; i++) ref_buf[i] = ref_mem[row*PS + i];
    ref_col = col;
    wait_rb(PS + 2, "load");
  endtask

  task automatic read_chk(input int n, input string tag);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin host_rd(v); chk(tag, v, m_next()); end
  endtask

  // Program n bytes at col of row; column bit 8 is whatever the last read pointer left.
  task automatic do_prog(input int row, input int col, input int n,
                         input bit rnd, input logic [7:0] fill);
    logic [7:0] d;
    cmd(CMD_PROG);
    addr3(col[7:0], row[7:0], {7'b0, row[8]});
    ref_col = (ref_col & 'h100) | (col & 'hFF);
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : fill;
      host_wr(1'b0, 1'b0, d);
      ref_buf[ref_col] = d; ref_col = (ref_col + 1) % PS;
    end
    cmd(CMD_PROG_CFM);
    for (int i = 0; i < PS; i++) ref_mem[row*PS + i] = ref_buf[i];
  endtask

  initial begin
    logic [7:0] v;
    int row, col, nbad;
    for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = (i / PS == 5) ? 8'(i % PS) : 8'($urandom);
    init_mem = 1'b1;
    @(posedge clk); #1 init_mem = 1'b0;
    @(negedge clk);
    chk("rst_rb", F_RB, 1);       chk("rst_oe", F_IO_OE, 0);
    chk("rst_out", F_IO_OUT, 0);  chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);     chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Full page read of the ramp page.
    do_read_setup(5, 0);
    read_chk(PS, "rd_p5");

    // Fill a page with 0xA5, poll status while it is stored.
    row = 'h107;
    do_prog(row, 0, PS, 1'b0, 8'hA5);
    cmd(CMD_STATUS);
    host_rd(v); chk("stat_busy", v, STATUS_BUSY);
    chk("stat_rb_low", F_RB, 0);
    wait_rb(PS + 1, "store");
    host_rd(v); chk("stat_ready", v, STATUS_READY);
    nbad = 0;
    for (int i = 0; i < PS; i++) if (mem[row*PS + i] !== 8'hA5) nbad++;
    chk("prog_a5", nbad, 0);
    cmd(CMD_READ0);
    read_chk(4, "rd_after_stat");

    // Second-half pointer, read across the column wrap.
    do_read_setup(5, 'h110);
    read_chk(PS + 8, "rd_wrap");

    // Random partial/wrapping programs, each read back at a random column.
    for (int it = 0; it < 3; it++) begin
      row = $urandom_range(0, (1 << RW) - 1);
      col = $urandom_range(0, 255);
      do_prog(row, col, $urandom_range(1, 600), 1'b1, 8'h00);
      wait_rb(PS + 1, "store_rnd");
      do_read_setup(row, $urandom_range(0, PS - 1));
      read_chk(40, "rd_rnd");
    end

    // Abort a page load part-way through.
    row = $urandom_range(0, (1 << RW) - 1);
    cmd(CMD_READ0); addr3(8'h00, row[7:0], {7'b0, row[8]});
    repeat (97) @(negedge clk);
    cmd(CMD_RESET);
    chk("ff_rb", F_RB, 1); chk("ff_oe", F_IO_OE, 0); chk("ff_re", mem_re, 0);
    ref_col = 0;
    do_read_setup($urandom_range(0, (1 << RW) - 1), $urandom_range(0, PS - 1));
    read_chk(24, "rd_after_ff");

    // Asynchronous reset while the responder drives the bus.
    @(negedge clk); F_REN = 1'b0;
    @(negedge clk); chk("pre_rst_oe", F_IO_OE, 1);
    #2 rst = 1'b0;
    #1 chk("arst_oe", F_IO_OE, 0); chk("arst_rb", F_RB, 1); chk("arst_out", F_IO_OUT, 0);
    F_REN = 1'b1;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a load.
    cmd(CMD_READ0); addr3(8'h00, 8'h05, 8'h00);
    repeat (40) @(negedge clk);
    chk("mid_load_rb", F_RB, 0);
    #2 rst = 1'b0;
    #1 chk("arst_load_rb", F_RB, 1); chk("arst_load_re", mem_re, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    nbad = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_image", nbad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
